booth_seq_ctrl: RTL and testbench
=================================

Name: booth_seq_ctrl

Overview:
- Clocked control unit that sequences the radix-2 Booth multiplier datapath directly downstream of it.
- Accepts a start/operand request and latches the operands.
- Emits one 2-bit datapath command per cycle (INIT/ADD/SUB/SHIFT), reads back the datapath status {B[0], FIN}, and tracks the Booth Q(-1) bit internally.
- Captures the finished product, pulses done, and flags an error if FIN never arrives.

Parameters:
BIT_LEN, 4, operand width; product width is 2*BIT_LEN.
MAX_SHIFT, 2*BIT_LEN, number of SHIFT commands after which FIN is expected.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request; sampled only in IDLE.
in1  in  BIT_LEN  multiplicand; latched on accepted start.
in2  in  BIT_LEN  multiplier; latched on accepted start.
op_a  out  BIT_LEN  latched multiplicand to datapath IN1.
op_b  out  BIT_LEN  latched multiplier to datapath IN2.
state  out  2  datapath command: 00 INIT, 01 ADD, 10 SUB, 11 SHIFT.
signal  in  2  datapath status: [1] = B[0], [0] = FIN.
prod_in  in  2*BIT_LEN  datapath product {X,B}.
busy  out  1  high from accepted start until DONE is left.
done  out  1  one-cycle pulse in the DONE state.
err  out  1  sticky timeout flag; cleared on the next accepted start.
result  out  2*BIT_LEN  captured product; holds its value until the next capture.

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE. state=00, op_a=op_b=0, result=0, busy=done=err=0, qm1=0, shift_cnt=0.
  - Reset asserted mid-operation aborts immediately; no done pulse, result unchanged from its reset value.
- All outputs are registered. signal and prod_in are sampled at a rising edge and reflect the command held during the preceding cycle.
- FSM states: IDLE, LOAD, OP, SHIFT, DONE.
- IDLE: state=00.
  - start=1 → LOAD. On the same edge: latch op_a=in1, op_b=in2; set busy=1, qm1=0, shift_cnt=0, err=0.
- LOAD: state=00 for exactly one cycle. At the end of the cycle, run the decide rule.
- Decide rule, using pair (signal[1], qm1):
  - 10 → OP with state=SUB.
  - 01 → OP with state=ADD.
  - 00 or 11 → SHIFT.
  - Whenever SHIFT is entered (from LOAD, OP or SHIFT): qm1 <= signal[1], i.e. the pre-shift B[0].
- OP: one cycle carrying ADD or SUB, then unconditionally → SHIFT.
  - signal[1] is unaffected by ADD/SUB; the SHIFT-entry qm1 capture uses the value sampled at the end of OP.
- SHIFT: state=11 for one cycle; shift_cnt increments on the edge leaving SHIFT.
- End of a SHIFT cycle, in priority order:
  1. signal[0]=1 (FIN) → DONE; result <= prod_in.
  2. shift_cnt+1 > MAX_SHIFT without FIN → DONE; err <= 1; result unchanged.
  3. Otherwise apply the decide rule.
- FIN seen at the end of LOAD or OP is ignored; only post-SHIFT sampling ends the operation.
- DONE: state=00, done=1 for one cycle, busy=1. Next → IDLE with busy=0.
- start while busy: ignored, never queued.
- start in the same cycle as DONE: ignored; start in IDLE on the following cycle is accepted. Minimum back-to-back spacing is one IDLE cycle.
- Command rules:
  - Never two ADD/SUB commands in a row.
  - Every ADD/SUB is immediately followed by SHIFT.
- Latency, start edge to done pulse = 1 (LOAD) + MAX_SHIFT (SHIFT) + number of OP cycles + 1 (DONE).
- shift_cnt is wide enough to hold MAX_SHIFT+1 with no wrap.

Test Plan:
- Bench uses a behavioural datapath stub: it returns B[0] bits of op_b LSB-first then zeros, asserts FIN after MAX_SHIFT shifts, and drives prod_in=8'hA5. Run with BIT_LEN=4, MAX_SHIFT=4.
- Basic sequence: in1=3, in2=4'b0110, start one cycle.
  - Required state sequence: 00, 11, 10, 11, 11, 01, 11, then 00 in DONE.
  - done pulses 8 cycles after start; result=8'hA5; err=0.
- All-ones multiplier: in2=4'b1111.
  - Sequence: 00, 10, 11, 11, 11, 11, then DONE.
  - Exactly one SUB; latency 7.
- Timeout: stub never asserts FIN.
  - After 5 SHIFTs: err=1, done pulses, result holds its prior value.
  - The next start clears err.
- Start while busy: pulse start in the 3rd cycle of an operation → ignored; only one done.
  - start asserted during DONE → ignored.
  - start one cycle after DONE → accepted.
- Reset mid-operation: drop rst_n during the OP cycle.
  - Outputs go to 0 immediately (asynchronously).
  - After release, FSM is in IDLE; a new start completes normally.

Source files
------------

// File: rtl/booth_seq_ctrl.sv
// Sequencer for a radix-2 Booth multiplier datapath: issues INIT/ADD/SUB/SHIFT
// commands, tracks Q(-1), and captures the product or flags a missing FIN.
module booth_seq_ctrl #(
   parameter int BIT_LEN   = 4,
   parameter int MAX_SHIFT = 2*BIT_LEN
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [BIT_LEN-1:0]   in1,
   input  logic [BIT_LEN-1:0]   in2,
   output logic [BIT_LEN-1:0]   op_a,
   output logic [BIT_LEN-1:0]   op_b,
   output logic [1:0]           state,
   input  logic [1:0]           signal,
   input  logic [2*BIT_LEN-1:0] prod_in,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [2*BIT_LEN-1:0] result
);

   localparam logic [1:0] CMD_INIT  = 2'b00;
   localparam logic [1:0] CMD_ADD   = 2'b01;
   localparam logic [1:0] CMD_SUB   = 2'b10;
   localparam logic [1:0] CMD_SHIFT = 2'b11;

   // Counter must reach MAX_SHIFT+1 so the timeout compare never wraps.
   localparam int CW = $clog2(MAX_SHIFT + 2);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_SHIFT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_OP,
      S_SHIFT,
      S_DONE
   } fsm_t;

   fsm_t          fsm;
   fsm_t          dec_fsm;
   logic [1:0]    dec_cmd;
   logic          qm1;
   logic [CW-1:0] shift_cnt;
   logic [CW-1:0] cnt_nxt;

   assign cnt_nxt = shift_cnt + CW'(1);

   // Booth pair {B[0], Q(-1)} picks the next command.
   always_comb begin
      dec_fsm = S_SHIFT;
      dec_cmd = CMD_SHIFT;
      case ({signal[1], qm1})
         2'b10: begin
            dec_fsm = S_OP;
            dec_cmd = CMD_SUB;
         end
         2'b01: begin
            dec_fsm = S_OP;
            dec_cmd = CMD_ADD;
         end
         default: begin
            dec_fsm = S_SHIFT;
            dec_cmd = CMD_SHIFT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm       <= S_IDLE;
         state     <= CMD_INIT;
         op_a      <= '0;
         op_b      <= '0;
         result    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         qm1       <= 1'b0;
         shift_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (fsm)
            S_IDLE: begin
               state <= CMD_INIT;
               if (start) begin
                  fsm       <= S_LOAD;
                  op_a      <= in1;
                  op_b      <= in2;
                  busy      <= 1'b1;
                  qm1       <= 1'b0;
                  shift_cnt <= '0;
                  err       <= 1'b0;
               end
            end
            S_LOAD: begin
               fsm   <= dec_fsm;
               state <= dec_cmd;
               if (dec_fsm == S_SHIFT) qm1 <= signal[1];
            end
            S_OP: begin
               fsm   <= S_SHIFT;
               state <= CMD_SHIFT;
               qm1   <= signal[1];
            end
            S_SHIFT: begin
               shift_cnt <= cnt_nxt;
               if (signal[0]) begin
                  fsm    <= S_DONE;
                  state  <= CMD_INIT;
                  done   <= 1'b1;
                  result <= prod_in;
               end else if (cnt_nxt > MAX_CNT) begin
                  fsm   <= S_DONE;
                  state <= CMD_INIT;
                  done  <= 1'b1;
                  err   <= 1'b1;
               end else begin
                  fsm   <= dec_fsm;
                  state <= dec_cmd;
                  if (dec_fsm == S_SHIFT) qm1 <= signal[1];
               end
            end
            S_DONE: begin
               fsm   <= S_IDLE;
               state <= CMD_INIT;
               busy  <= 1'b0;
            end
            default: begin
               fsm   <= S_IDLE;
               state <= CMD_INIT;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Scoreboard bench for booth_seq_ctrl with a behavioural datapath stub.
module tb_booth_seq_ctrl;

   localparam int BIT_LEN   = 4;
   localparam int MAX_SHIFT = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [3:0]   in1, in2, op_a, op_b;
   logic [1:0]   cmd, sig;
   logic [7:0]   prod_in, result;
   logic         busy, done, err;

   booth_seq_ctrl #(.BIT_LEN(BIT_LEN), .MAX_SHIFT(MAX_SHIFT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in1(in1), .in2(in2),
      .op_a(op_a), .op_b(op_b), .state(cmd), .signal(sig), .prod_in(prod_in),
      .busy(busy), .done(done), .err(err), .result(result)
   );

   always #5 clk = ~clk;

   // Datapath stub: status reflects the command held in the current cycle.
   int   sh_cnt;
   int   eff;
   logic fin_en;
   always @(posedge clk) begin
      if (!busy) sh_cnt <= 0;
      else if (cmd == 2'b11) sh_cnt <= sh_cnt + 1;
   end
   always_comb begin
      eff    = sh_cnt + ((cmd == 2'b11) ? 1 : 0);
      sig[1] = (eff < BIT_LEN) ? op_b[eff[1:0]] : 1'b0;
      sig[0] = fin_en && (eff >= MAX_SHIFT);
   end

   typedef struct {
      logic [7:0]  res;
      logic        er;
      logic [31:0] trace;
      int          lat;
   } exp_t;
   exp_t exp_q[$];

   int n_checks = 0;
   int n_errs   = 0;
   int done_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errs++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   task automatic push_exp(input logic [7:0] r, input logic e, input logic [31:0] t, input int l);
      exp_t x;
      x.res = r; x.er = e; x.trace = t; x.lat = l;
      exp_q.push_back(x);
   endtask

   // Monitor: records commands while busy, checks against scoreboard on done.
   logic [31:0] trace;
   int          lat;
   logic        prev_op;
   always @(negedge clk) begin
      if (!rst_n) begin
         trace = '0; lat = 0; prev_op = 1'b0;
      end else if (busy) begin
         trace = {trace[29:0], cmd};
         lat++;
         if (prev_op) chk("shift_after_op", {30'd0, cmd}, 32'd3);
         prev_op = (cmd == 2'b01) || (cmd == 2'b10);
         if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_t x;
               x = exp_q.pop_front();
               chk("result", {24'd0, result}, {24'd0, x.res});
               chk("err", {31'd0, err}, {31'd0, x.er});
               chk("cmd_trace", trace, x.trace);
               chk("latency", lat, x.lat);
            end
            trace = '0; lat = 0; prev_op = 1'b0;
         end
      end
   end

   task automatic start_op(input logic [3:0] a, input logic [3:0] b);
      in1 = a; in2 = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      logic seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         seen = done;
         if (!seen) @(negedge clk);
      end
      chk("done_seen", {31'd0, seen}, 32'd1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_state"}, {30'd0, cmd}, 32'd0);
      chk({tag, "_ops"}, {24'd0, op_a, op_b}, 32'd0);
      chk({tag, "_result"}, {24'd0, result}, 32'd0);
      chk({tag, "_flags"}, {29'd0, busy, done, err}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; in1 = '0; in2 = '0;
      fin_en = 1'b1; prod_in = 8'hA5;
      #3 chk_zero("reset");
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic: 00,11,10,11,11,01,11,00
      push_exp(8'hA5, 1'b0, 32'h3BDC, 8);
      start_op(4'd3, 4'b0110);
      wait_done(); @(negedge clk);

      // All-ones multiplier: 00,10,11,11,11,11,00
      push_exp(8'hA5, 1'b0, 32'h0BFC, 7);
      start_op(4'd7, 4'b1111);
      wait_done(); @(negedge clk);

      // Timeout: five shifts, result keeps A5 although stub drives 3C
      fin_en = 1'b0; prod_in = 8'h3C;
      push_exp(8'hA5, 1'b1, 32'h0FFC, 7);
      start_op(4'd9, 4'b0000);
      wait_done(); @(negedge clk);
      chk("err_sticky", {31'd0, err}, 32'd1);
      chk("result_hold", {24'd0, result}, 32'h0000_00A5);

      // Next start clears err: 00,10,11,01,11,11,11,00
      fin_en = 1'b1; prod_in = 8'h5A;
      push_exp(8'h5A, 1'b0, 32'h2DFC, 8);
      start_op(4'd5, 4'b0001);
      chk("err_cleared", {31'd0, err}, 32'd0);
      wait_done(); @(negedge clk);
      prod_in = 8'hA5;

      // Start while busy (cycle 3), during DONE, and one cycle after DONE
      push_exp(8'hA5, 1'b0, 32'h3BDC, 8);
      start_op(4'd3, 4'b0110);
      @(negedge clk);
      in2 = 4'b0001; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      push_exp(8'hA5, 1'b0, 32'h0BFC, 7);
      in1 = 4'd7; in2 = 4'b1111; start = 1'b1;
      @(negedge clk);
      chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
      @(negedge clk);
      start = 1'b0;
      chk("start_after_done", {31'd0, busy}, 32'd1);
      wait_done(); @(negedge clk);

      // Reset during the OP cycle
      start_op(4'd3, 4'b0110);
      @(negedge clk); @(negedge clk);
      chk("op_before_reset", {30'd0, cmd}, 32'd2);
      #2 rst_n = 1'b0;
      #1 chk_zero("midreset");
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", {30'd0, cmd, busy}, 32'd0);
      push_exp(8'hA5, 1'b0, 32'h3BDC, 8);
      start_op(4'd3, 4'b0110);
      wait_done(); @(negedge clk);

      repeat (3) @(negedge clk);
      chk("done_count", done_cnt, 7);
      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
